// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, control bundle type and immediate/ALU helpers
// used by the decode stage, its register file and its port interface.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       result_src;
    logic [2:0] alu_control;
  } ctrl_t;

  function automatic logic [2:0] alu_from_funct3(input logic [2:0] funct3, input logic sub);
    case (funct3)
      3'b000:  return sub ? ALU_SUB : ALU_ADD;
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b010:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // B-immediate keeps bit 0 as zero; the execute stage scales it for the word-addressed PC.
  function automatic logic [XLEN-1:0] imm_extend(input logic [31:0] instr, input logic [1:0] sel);
    case (sel)
      IMM_I:   return {{20{instr[31]}}, instr[31:20]};
      IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/decode_cycle_if.sv
// Decode-stage port bundle: IF/ID inputs, writeback port, flush/stall and the ID/EX outputs.
// master = the decode stage, slave = the surrounding pipeline.
interface decode_cycle_if;
  import riscv_pkg::*;

  logic [XLEN-1:0] instrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCplus4D;
  logic            FlushE;
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;
  logic            StallD;
  logic            RegWriteE;
  logic            MemWriteE;
  logic            BranchE;
  logic            ALUSrcE;
  logic            ResultSrcE;
  logic [2:0]      ALUControlE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [4:0]      Rs1E;
  logic [4:0]      Rs2E;
  logic [4:0]      RdE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCplus4E;

  modport master (
    input  instrD, PCD, PCplus4D, FlushE, RegWriteW, RdW, ResultW,
    output StallD, RegWriteE, MemWriteE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
           RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCplus4E
  );

  modport slave (
    output instrD, PCD, PCplus4D, FlushE, RegWriteW, RdW, ResultW,
    input  StallD, RegWriteE, MemWriteE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
           RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCplus4E
  );

endinterface

// File: rtl/reg_file.sv
// 32x32 register file, 2 combinational reads, 1 posedge write, x0 fixed at zero.
// REGFILE_BYPASS_EN: a same-cycle write to the read index is returned on that read port.
module reg_file
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
`ifdef REGFILE_BYPASS_EN
    if (we && wa != 5'd0 && wa == ra1) rd1 = wd;
    if (we && wa != 5'd0 && wa == ra2) rd2 = wd;
`else
`endif
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, immediate extend, load-use stall and the ID/EX register (1 cycle).
// Flush beats stall; both load an all-zero-control bubble. REGFILE_BYPASS_EN selects regfile write-through.
module decode_cycle
  import riscv_pkg::*;
(
  input logic            clk,
  input logic            rst,
  decode_cycle_if.master bus
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1_d, rs2_d, rd_d;
  ctrl_t           ctrl_d;
  logic [1:0]      imm_sel;
  logic            uses_rs2;
  logic [XLEN-1:0] imm_d, rd1_d, rd2_d;

  ctrl_t           ctrl_e;
  logic [XLEN-1:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e;
  logic [4:0]      rs1_e, rs2_e, rd_e;

  assign opcode = bus.instrD[6:0];
  assign funct3 = bus.instrD[14:12];
  assign rd_d   = bus.instrD[11:7];
  assign rs1_d  = bus.instrD[19:15];
  assign rs2_d  = bus.instrD[24:20];

  always_comb begin
    ctrl_d   = '0;
    imm_sel  = IMM_I;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_LOAD: begin
        ctrl_d.reg_write   = 1'b1;
        ctrl_d.alu_src     = 1'b1;
        ctrl_d.result_src  = 1'b1;
        ctrl_d.alu_control = ALU_ADD;
      end
      OP_STORE: begin
        ctrl_d.mem_write   = 1'b1;
        ctrl_d.alu_src     = 1'b1;
        ctrl_d.alu_control = ALU_ADD;
        imm_sel            = IMM_S;
        uses_rs2           = 1'b1;
      end
      OP_RTYPE: begin
        ctrl_d.reg_write   = 1'b1;
        ctrl_d.alu_control = alu_from_funct3(funct3, bus.instrD[30]);
        uses_rs2           = 1'b1;
      end
      OP_ITYPE: begin
        ctrl_d.reg_write   = 1'b1;
        ctrl_d.alu_src     = 1'b1;
        ctrl_d.alu_control = alu_from_funct3(funct3, 1'b0);
      end
      OP_BRANCH: begin
        ctrl_d.branch      = 1'b1;
        ctrl_d.alu_control = ALU_SUB;
        imm_sel            = IMM_B;
        uses_rs2           = 1'b1;
      end
      default: ;
    endcase
  end

  assign imm_d = imm_extend(bus.instrD, imm_sel);

  reg_file u_reg_file (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1_d),
    .ra2 (rs2_d),
    .rd1 (rd1_d),
    .rd2 (rd2_d),
    .we  (bus.RegWriteW),
    .wa  (bus.RdW),
    .wd  (bus.ResultW)
  );

  // Load in EX whose destination feeds this instruction: hold fetch for one cycle.
  assign bus.StallD = !bus.FlushE && ctrl_e.result_src && rd_e != 5'd0 &&
                      (rd_e == rs1_d || (uses_rs2 && rd_e == rs2_d));

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_e <= '0;
      rd1_e  <= '0;
      rd2_e  <= '0;
      imm_e  <= '0;
      rs1_e  <= '0;
      rs2_e  <= '0;
      rd_e   <= '0;
      pc_e   <= '0;
      pc4_e  <= '0;
    end else begin
      ctrl_e <= (bus.FlushE || bus.StallD) ? '0 : ctrl_d;
      rd1_e  <= rd1_d;
      rd2_e  <= rd2_d;
      imm_e  <= imm_d;
      rs1_e  <= rs1_d;
      rs2_e  <= rs2_d;
      rd_e   <= rd_d;
      pc_e   <= bus.PCD;
      pc4_e  <= bus.PCplus4D;
    end
  end

  assign bus.RegWriteE   = ctrl_e.reg_write;
  assign bus.MemWriteE   = ctrl_e.mem_write;
  assign bus.BranchE     = ctrl_e.branch;
  assign bus.ALUSrcE     = ctrl_e.alu_src;
  assign bus.ResultSrcE  = ctrl_e.result_src;
  assign bus.ALUControlE = ctrl_e.alu_control;
  assign bus.RD1E        = rd1_e;
  assign bus.RD2E        = rd2_e;
  assign bus.ImmExtE     = imm_e;
  assign bus.Rs1E        = rs1_e;
  assign bus.Rs2E        = rs2_e;
  assign bus.RdE         = rd_e;
  assign bus.PCE         = pc_e;
  assign bus.PCplus4E    = pc4_e;

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: directed pipeline scenarios then random traffic, checked by a
// scoreboard against an instruction-level reference model; REGFILE_BYPASS_EN aware.
module tb_decode_cycle;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_cycle_if bus ();

  decode_cycle dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic        rw, mw, br, as, rs;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    bit          bubble, imm_dc, stall;
  } exp_t;

  exp_t        q[$];
  exp_t        cur_ex;
  exp_t        mon_e;
  logic [31:0] regs [32];
  bit          prev_stall;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t zero_ex();
    exp_t m;
    m.rw = 0; m.mw = 0; m.br = 0; m.as = 0; m.rs = 0; m.alu = 3'b000;
    m.rd1 = 0; m.rd2 = 0; m.imm = 0; m.pc = 0; m.pc4 = 0;
    m.rs1 = 0; m.rs2 = 0; m.rd = 0;
    m.bubble = 0; m.imm_dc = 0; m.stall = 0;
    return m;
  endfunction

  function automatic logic [2:0] alu_of(input int f3, input bit sub);
    case (f3)
      0:       return sub ? 3'b001 : 3'b000;
      7:       return 3'b010;
      6:       return 3'b011;
      2:       return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return regs[a];
  endfunction

  function automatic bit uses_rs2(input logic [31:0] ins);
    int op;
    op = int'(ins & 32'h7f);
    return op == 'h23 || op == 'h33 || op == 'h63;
  endfunction

  // Instruction-level decode using integer arithmetic for the immediates.
  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] pc4);
    exp_t m;
    int   s, op, f3;
    m  = zero_ex();
    s  = int'(ins);
    op = int'(ins & 32'h7f);
    f3 = int'((ins >> 12) & 32'h7);
    m.rs1 = ins[19:15];
    m.rs2 = ins[24:20];
    m.rd  = ins[11:7];
    m.pc  = pc;
    m.pc4 = pc4;
    case (op)
      'h03: begin m.rw = 1; m.as = 1; m.rs = 1; m.alu = 3'b000; m.imm = 32'(s >>> 20); end
      'h23: begin m.mw = 1; m.as = 1; m.alu = 3'b000;
                  m.imm = 32'((s >>> 25) * 32 + int'((ins >> 7) & 32'h1f)); end
      'h33: begin m.rw = 1; m.alu = alu_of(f3, ins[30]); m.imm_dc = 1; end
      'h13: begin m.rw = 1; m.as = 1; m.alu = alu_of(f3, 1'b0); m.imm = 32'(s >>> 20); end
      'h63: begin m.br = 1; m.alu = 3'b001;
                  m.imm = 32'((s >>> 31) * 4096 + int'((ins >> 7) & 32'h1) * 2048 +
                              int'((ins >> 25) & 32'h3f) * 32 + int'((ins >> 8) & 32'hf) * 2); end
      default: m.imm_dc = 1;
    endcase
    return m;
  endfunction

  // One clock of stimulus: expectation for the current cycle is queued, the model steps to the next.
  task automatic drive(input logic r, input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e, nx;
    bit   stall;
    rst           = r;
    bus.instrD    = ins;
    bus.PCD       = pc;
    bus.PCplus4D  = pc + 32'd1;
    bus.FlushE    = fl;
    bus.RegWriteW = we;
    bus.RdW       = wa;
    bus.ResultW   = wd;
    stall = !fl && cur_ex.rs && cur_ex.rd != 0 &&
            (cur_ex.rd == ins[19:15] || (uses_rs2(ins) && cur_ex.rd == ins[24:20]));
    e       = cur_ex;
    e.stall = stall;
    q.push_back(e);
    if (r) begin
      cur_ex = zero_ex();
      for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    end else begin
      nx     = model_decode(ins, pc, pc + 32'd1);
      nx.rd1 = rf_read(ins[19:15], we, wa, wd);
      nx.rd2 = rf_read(ins[24:20], we, wa, wd);
      if (fl || stall) begin
        nx.rw = 0; nx.mw = 0; nx.br = 0; nx.as = 0; nx.rs = 0; nx.alu = 3'b000;
        nx.bubble = 1;
      end
      cur_ex = nx;
      if (we && wa != 0) regs[wa] = wd;
    end
    prev_stall = stall;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("StallD",      32'(bus.StallD),      32'(mon_e.stall));
      check("RegWriteE",   32'(bus.RegWriteE),   32'(mon_e.rw));
      check("MemWriteE",   32'(bus.MemWriteE),   32'(mon_e.mw));
      check("BranchE",     32'(bus.BranchE),     32'(mon_e.br));
      check("ALUSrcE",     32'(bus.ALUSrcE),     32'(mon_e.as));
      check("ResultSrcE",  32'(bus.ResultSrcE),  32'(mon_e.rs));
      check("ALUControlE", 32'(bus.ALUControlE), 32'(mon_e.alu));
      if (!mon_e.bubble) begin
        check("RD1E",     bus.RD1E,         mon_e.rd1);
        check("RD2E",     bus.RD2E,         mon_e.rd2);
        check("Rs1E",     32'(bus.Rs1E),    32'(mon_e.rs1));
        check("Rs2E",     32'(bus.Rs2E),    32'(mon_e.rs2));
        check("RdE",      32'(bus.RdE),     32'(mon_e.rd));
        check("PCE",      bus.PCE,          mon_e.pc);
        check("PCplus4E", bus.PCplus4E,     mon_e.pc4);
        if (!mon_e.imm_dc) check("ImmExtE", bus.ImmExtE, mon_e.imm);
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [4:0]  r1, r2, rd;
    logic [2:0]  f3;
    logic [31:0] rnd, ins;
    logic [2:0]  f3_tab [4];
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b111; f3_tab[2] = 3'b110; f3_tab[3] = 3'b010;
    r1  = 5'($urandom_range(0, 7));
    r2  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    f3  = f3_tab[$urandom_range(0, 3)];
    rnd = $urandom;
    case ($urandom_range(0, 5))
      0: ins = {rnd[31:20], r1, 3'b010, rd, 7'b0000011};
      1: ins = {rnd[31:25], r2, r1, 3'b010, rnd[11:7], 7'b0100011};
      2: ins = {1'b0, (f3 == 3'b000) ? rnd[30] : 1'b0, 5'b0, r2, r1, f3, rd, 7'b0110011};
      3: ins = {rnd[31:20], r1, f3, rd, 7'b0010011};
      4: ins = {rnd[31:25], r2, r1, 3'b000, rnd[11:7], 7'b1100011};
      default: begin
        ins = rnd;
        if (uses_rs2(ins) || ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0010011)
          ins[6:0] = 7'b0110111;
      end
    endcase
    return ins;
  endfunction

  initial begin
    logic [31:0] ins, pc;
    cur_ex     = zero_ex();
    prev_stall = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    rst = 1'b1;
    bus.instrD = 32'h01AC89B3; bus.PCD = 0; bus.PCplus4D = 0; bus.FlushE = 0;
    bus.RegWriteW = 0; bus.RdW = 0; bus.ResultW = 0;
    @(posedge clk);
    #1;

    // Reset held with a live instruction on instrD.
    drive(1, 32'h01AC89B3, 32'h10, 0, 0, 0, 0);

    // x8 = 0x100 via writeback, then lw s2,40(s0).
    drive(0, 32'h00000013, 32'h20, 0, 1, 5'd8, 32'h100);
    drive(0, 32'h02842903, 32'h21, 0, 0, 0, 0);
    check("lw_RegWriteE",  32'(bus.RegWriteE),  32'd1);
    check("lw_ResultSrcE", 32'(bus.ResultSrcE), 32'd1);
    check("lw_ALUSrcE",    32'(bus.ALUSrcE),    32'd1);
    check("lw_ImmExtE",    bus.ImmExtE,         32'd40);
    check("lw_RD1E",       bus.RD1E,            32'h100);
    check("lw_RdE",        32'(bus.RdE),        32'd18);

    // Independent add behind the load, then a dependent sub that must stall once.
    drive(0, 32'h01AC89B3, 32'h22, 0, 0, 0, 0);
    drive(0, 32'h02842903, 32'h23, 0, 0, 0, 0);
    drive(0, 32'h41890A33, 32'h24, 0, 0, 0, 0);
    check("stall_bubble_RegWriteE", 32'(bus.RegWriteE), 32'd0);
    drive(0, 32'h41890A33, 32'h24, 0, 0, 0, 0);
    check("after_stall_ALUControlE", 32'(bus.ALUControlE), 32'd1);
    check("after_stall_RegWriteE",   32'(bus.RegWriteE),   32'd1);

    // sw s6,20(t4)
    drive(0, 32'h016EAA23, 32'h25, 0, 0, 0, 0);
    check("sw_MemWriteE", 32'(bus.MemWriteE), 32'd1);
    check("sw_RegWriteE", 32'(bus.RegWriteE), 32'd0);
    check("sw_ImmExtE",   bus.ImmExtE,        32'd20);
    check("sw_Rs1E",      32'(bus.Rs1E),      32'd29);
    check("sw_Rs2E",      32'(bus.Rs2E),      32'd22);

    // Flush coinciding with a load-use match.
    drive(0, 32'h02842903, 32'h26, 0, 0, 0, 0);
    drive(0, 32'h41890A33, 32'h27, 1, 0, 0, 0);
    check("flush_ctrl", {27'd0, bus.RegWriteE, bus.MemWriteE, bus.BranchE, bus.ALUSrcE, bus.ResultSrcE}, 32'd0);

    // Same-cycle writeback of x19 while reading it, then a dropped write to x0.
    drive(0, 32'h00098293, 32'h28, 0, 1, 5'd19, 32'hDEAD);
`ifdef REGFILE_BYPASS_EN
    check("wb_same_cycle_RD1E", bus.RD1E, 32'hDEAD);
`else
    check("wb_same_cycle_RD1E", bus.RD1E, 32'h0);
`endif
    drive(0, 32'h00000013, 32'h29, 0, 1, 5'd0, 32'h1234);
    drive(0, 32'h00000313, 32'h2A, 0, 0, 0, 0);
    check("x0_read_RD1E", bus.RD1E, 32'h0);
    drive(0, 32'h00098393, 32'h2B, 0, 0, 0, 0);
    check("x19_later_RD1E", bus.RD1E, 32'hDEAD);

    // Random traffic; fetch holds instrD/PCD while a stall is requested.
    ins = rand_instr();
    pc  = $urandom;
    for (int n = 0; n < 600; n++) begin
      if (!prev_stall) begin
        ins = rand_instr();
        pc  = $urandom;
      end
      drive(($urandom_range(0, 99) == 0), ins, pc, ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
